// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared RV32I core definitions: load/store funct3 codes,
//                LSU state type and op legality / byte-enable helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // funct3[1:0] encodes access size for every legal load/store code
    function automatic logic op_fault(input logic       is_store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] off);
        logic bad_f3;
        if (is_store)
            bad_f3 = (funct3 >= 3'b011);
        else
            bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        case (funct3[1:0])
            2'b01:   op_fault = bad_f3 | off[0];
            2'b10:   op_fault = bad_f3 | (off != 2'b00);
            default: op_fault = bad_f3;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                               input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   byte_enable = 4'b0001 << off;
            2'b01:   byte_enable = off[1] ? 4'b1100 : 4'b0011;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Selects the addressed byte/half/word of a read word and
//                sign- or zero-extends it to 32 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import cpu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_byte_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[8*i_byte_off +: 8];
    assign w_half = i_rdata[16*i_byte_off[1] +: 16];

    always_comb begin
        o_result = '0;
        case (i_funct3)
            LB:      o_result = {{24{w_byte[7]}}, w_byte};
            LH:      o_result = {{16{w_half[15]}}, w_half};
            LW:      o_result = i_rdata;
            LBU:     o_result = {24'h0, w_byte};
            LHU:     o_result = {16'h0, w_half};
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I memory stage: LB/LH/LW/LBU/LHU/SB/SH/SW over a
//                req/gnt/rvalid data-memory handshake, stalling the core.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsu_valid,
    input  logic                  lsu_is_store,
    input  logic [2:0]            lsu_funct3,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [31:0]           lsu_store_data,
    output logic                  lsu_stall,
    output logic                  lsu_done,
    output logic                  lsu_fault,
    output logic [31:0]           lsu_load_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t            r_state;
    lsu_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_store_data;
    logic [2:0]            r_funct3;
    logic                  r_is_store;
    logic                  r_fault;
    logic [31:0]           r_load_data;
    logic                  w_accept;
    logic                  w_accept_fault;
    logic [31:0]           w_ext_data;
    logic [31:0]           w_wdata;

    assign w_accept       = (r_state == IDLE) && lsu_valid;
    assign w_accept_fault = op_fault(lsu_is_store, lsu_funct3, lsu_addr[1:0]);

    load_extend u_load_extend (
        .i_rdata    (mem_rdata),
        .i_byte_off (r_addr[1:0]),
        .i_funct3   (r_funct3),
        .o_result   (w_ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (lsu_valid) w_next_state = w_accept_fault ? DONE : REQ;
            REQ:     if (mem_gnt) w_next_state = WAIT;
            WAIT:    if (mem_rvalid) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Op registers are captured at accept so the execute stage may move on
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr       <= '0;
            r_store_data <= '0;
            r_funct3     <= '0;
            r_is_store   <= 1'b0;
            r_fault      <= 1'b0;
            r_load_data  <= '0;
        end else if (w_accept) begin
            r_addr       <= lsu_addr;
            r_store_data <= lsu_store_data;
            r_funct3     <= lsu_funct3;
            r_is_store   <= lsu_is_store;
            r_fault      <= w_accept_fault;
            r_load_data  <= '0;
        end else if ((r_state == WAIT) && mem_rvalid && !r_is_store) begin
            r_load_data  <= w_ext_data;
        end
    end

    always_comb begin
        w_wdata = r_store_data;
        case (r_funct3)
            SB:      w_wdata = {4{r_store_data[7:0]}};
            SH:      w_wdata = {2{r_store_data[15:0]}};
            SW:      w_wdata = r_store_data;
            default: w_wdata = r_store_data;
        endcase
    end

    always_comb begin
        lsu_stall     = 1'b0;
        lsu_done      = 1'b0;
        lsu_fault     = 1'b0;
        lsu_load_data = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_be        = '0;
        mem_wdata     = '0;
        case (r_state)
            // reset gates the accept stall so every output reads 0 while held in reset
            IDLE: lsu_stall = lsu_valid & reset;
            REQ: begin
                lsu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = r_is_store;
                mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_be    = byte_enable(r_funct3, r_addr[1:0]);
                mem_wdata = w_wdata;
            end
            WAIT: lsu_stall = 1'b1;
            DONE: begin
                lsu_done      = 1'b1;
                lsu_fault     = r_fault;
                lsu_load_data = r_load_data;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit: directed ops with
//                literal expectations plus an access-rule model compared
//                every cycle a request or completion is visible.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        lsu_valid;
    logic        lsu_is_store;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_store_data;
    logic        lsu_stall;
    logic        lsu_done;
    logic        lsu_fault;
    logic [31:0] lsu_load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int errors   = 0;
    int req_cnt  = 0;
    int done_cnt = 0;

    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_fault;
    logic [31:0] exp_load;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .lsu_valid      (lsu_valid),
        .lsu_is_store   (lsu_is_store),
        .lsu_funct3     (lsu_funct3),
        .lsu_addr       (lsu_addr),
        .lsu_store_data (lsu_store_data),
        .lsu_stall      (lsu_stall),
        .lsu_done       (lsu_done),
        .lsu_fault      (lsu_fault),
        .lsu_load_data  (lsu_load_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected outcome derived from the RV32I access rules by plain arithmetic
    task automatic set_model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] rdata);
        int          size;
        int          off;
        int          lane;
        bit          legal;
        logic [31:0] v;
        off   = int'(addr % 4);
        size  = 1 << (f3 % 4);
        legal = st ? (f3 < 3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        exp_fault = !legal || ((off % size) != 0);
        exp_we    = st;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_be    = 4'(((1 << size) - 1) << off);
        if (size == 1)      exp_wdata = data[7:0] * 32'h0101_0101;
        else if (size == 2) exp_wdata = data[15:0] * 32'h0001_0001;
        else                exp_wdata = data;
        v = 32'h0;
        if (!st && !exp_fault) begin
            lane = (size == 1) ? off : (size == 2) ? (off & 2) : 0;
            v = rdata >> (8 * lane);
            if (size == 1) begin
                v = v & 32'hFF;
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
        end
        exp_load = v;
    endtask

    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            req_cnt++;
            check("model_mem_we", {31'h0, mem_we}, {31'h0, exp_we});
            check("model_mem_addr", mem_addr, exp_addr);
            check("model_mem_be", {28'h0, mem_be}, {28'h0, exp_be});
            if (exp_we) check("model_mem_wdata", mem_wdata, exp_wdata);
        end
        if (lsu_done === 1'b1) begin
            done_cnt++;
            check("model_fault", {31'h0, lsu_fault}, {31'h0, exp_fault});
            check("model_load_data", lsu_load_data, exp_load);
        end
    end

    // Entered and left just after a rising edge with the DUT idle
    task automatic run_op(input string tag, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input bit lit_fault, input logic [3:0] lit_be,
                          input logic [31:0] lit_wdata, input logic [31:0] lit_load);
        int req0;
        int done0;
        set_model(st, f3, addr, data, rdata);
        lsu_valid      = 1'b1;
        lsu_is_store   = st;
        lsu_funct3     = f3;
        lsu_addr       = addr;
        lsu_store_data = data;
        @(negedge clk);
        check({tag, "_stall_accept"}, {31'h0, lsu_stall}, 32'h1);
        req0  = req_cnt;
        done0 = done_cnt;
        @(posedge clk); #1;
        lsu_valid      = 1'b0;
        lsu_is_store   = ~st;
        lsu_funct3     = 3'b011;
        lsu_addr       = ~addr;
        lsu_store_data = ~data;
        if (!lit_fault) begin
            for (int i = 0; i < gnt_dly; i++) begin
                @(negedge clk);
                check({tag, "_stall_req"}, {31'h0, lsu_stall}, 32'h1);
                @(posedge clk); #1;
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            check({tag, "_req"}, {31'h0, mem_req}, 32'h1);
            check({tag, "_be"}, {28'h0, mem_be}, {28'h0, lit_be});
            if (st) check({tag, "_wdata"}, mem_wdata, lit_wdata);
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            for (int i = 0; i < rv_dly; i++) begin
                @(negedge clk);
                check({tag, "_stall_wait"}, {31'h0, lsu_stall}, 32'h1);
                check({tag, "_req_dropped"}, {31'h0, mem_req}, 32'h0);
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
        end
        @(negedge clk);
        check({tag, "_done"}, {31'h0, lsu_done}, 32'h1);
        check({tag, "_fault"}, {31'h0, lsu_fault}, {31'h0, lit_fault});
        check({tag, "_load"}, lsu_load_data, lit_load);
        check({tag, "_stall_done"}, {31'h0, lsu_stall}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_single_done"}, {31'h0, lsu_done}, 32'h0);
        check({tag, "_done_count"}, done_cnt - done0, 32'h1);
        check({tag, "_req_cycles"}, req_cnt - req0, lit_fault ? 32'h0 : 32'(gnt_dly + 1));
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'h0, lsu_stall}, 32'h0);
        check({tag, "_done"}, {31'h0, lsu_done}, 32'h0);
        check({tag, "_fault"}, {31'h0, lsu_fault}, 32'h0);
        check({tag, "_load"}, lsu_load_data, 32'h0);
        check({tag, "_mem"}, {27'h0, mem_req, mem_we, mem_be}, 32'h0);
        check({tag, "_addr_wdata"}, mem_addr | mem_wdata, 32'h0);
    endtask

    initial begin
        int done0;
        reset          = 1'b0;
        lsu_valid      = 1'b0;
        lsu_is_store   = 1'b0;
        lsu_funct3     = 3'b000;
        lsu_addr       = 32'h0;
        lsu_store_data = 32'h0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        //      tag      st  f3      addr          data          g  r  rdata         flt be       wdata         load
        run_op("lw",     0, 3'b010, 32'h0000_0100, 32'h0,        0, 0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
        run_op("lb",     0, 3'b000, 32'h0000_0103, 32'h0,        0, 0, 32'h8011_2233, 0, 4'b1000, 32'h0,        32'hFFFF_FF80);
        run_op("lbu",    0, 3'b100, 32'h0000_0103, 32'h0,        0, 0, 32'h8011_2233, 0, 4'b1000, 32'h0,        32'h0000_0080);
        run_op("lhu",    0, 3'b101, 32'h0000_0102, 32'h0,        0, 0, 32'h8011_2233, 0, 4'b1100, 32'h0,        32'h0000_8011);
        run_op("lh_hi",  0, 3'b001, 32'h0000_0102, 32'h0,        0, 1, 32'h8011_2233, 0, 4'b1100, 32'h0,        32'hFFFF_8011);
        run_op("lh_lo",  0, 3'b001, 32'h0000_0100, 32'h0,        1, 0, 32'h8011_2233, 0, 4'b0011, 32'h0,        32'h0000_2233);
        run_op("sb",     1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 0, 0, 32'hFFFF_FFFF, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        run_op("sh",     1, 3'b001, 32'h0000_0102, 32'h0000_1234, 0, 0, 32'h0,        0, 4'b1100, 32'h1234_1234, 32'h0);
        run_op("sw",     1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 1, 1, 32'h0,        0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        run_op("f_lw",   0, 3'b010, 32'h0000_0102, 32'h0,        0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
        run_op("f_l111", 0, 3'b111, 32'h0000_0100, 32'h0,        0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
        run_op("f_lh",   0, 3'b001, 32'h0000_0101, 32'h0,        0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
        run_op("f_sh",   1, 3'b001, 32'h0000_0103, 32'h0000_1234, 0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
        run_op("f_s011", 1, 3'b011, 32'h0000_0100, 32'h0,        0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
        run_op("slow",   0, 3'b010, 32'h0000_0200, 32'h0,        3, 2, 32'h0123_4567, 0, 4'b1111, 32'h0,        32'h0123_4567);

        // Reset while the op is waiting on its response
        set_model(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0);
        lsu_valid  = 1'b1;
        lsu_funct3 = 3'b010;
        lsu_addr   = 32'h0000_0300;
        lsu_is_store = 1'b0;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        check("rst_in_wait_stall", {31'h0, lsu_stall}, 32'h1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_async");
        done0 = done_cnt;
        @(posedge clk); #1;
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_stray_rvalid_done", {31'h0, lsu_done}, 32'h0);
            check("rst_stray_rvalid_stall", {31'h0, lsu_stall}, 32'h0);
        end
        check("rst_no_done_pulse", done_cnt - done0, 32'h0);
        @(posedge clk); #1;

        run_op("post_rst", 0, 3'b000, 32'h0000_0402, 32'h0, 0, 0, 32'h0055_0000, 0, 4'b0100, 32'h0, 32'h0000_0055);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
